// File: rtl/inert_pkg.sv
// Shared FSM states, SPI command words and timing constants for inert_intf.
// Define INERT_FAST_SIM_EN to shorten the power-up wait to 512 clocks.
package inert_pkg;

   typedef enum logic [3:0] {
      PWRUP,
      INIT1,
      INIT2,
      INIT3,
      INIT4,
      IDLE,
      RD1,
      RD2,
      RD3,
      RD4,
      RD5,
      RD6,
      RD7,
      RD8,
      DONE
   } state_t;

   localparam logic [15:0] INIT_CMD1 = 16'h0D02;
   localparam logic [15:0] INIT_CMD2 = 16'h1053;
   localparam logic [15:0] INIT_CMD3 = 16'h1150;
   localparam logic [15:0] INIT_CMD4 = 16'h1460;

   localparam logic [15:0] RD_CMD1 = 16'hA400;
   localparam logic [15:0] RD_CMD2 = 16'hA500;
   localparam logic [15:0] RD_CMD3 = 16'hA600;
   localparam logic [15:0] RD_CMD4 = 16'hA700;
   localparam logic [15:0] RD_CMD5 = 16'hAA00;
   localparam logic [15:0] RD_CMD6 = 16'hAB00;
   localparam logic [15:0] RD_CMD7 = 16'hAC00;
   localparam logic [15:0] RD_CMD8 = 16'hAD00;

   localparam int SCLK_DIV = 32;
   localparam int SCLK_W   = $clog2(SCLK_DIV);

   // Divider values on which the next clk edge drops / raises SCLK.
   localparam logic [SCLK_W-1:0] SCLK_FALL = SCLK_W'(SCLK_DIV / 2 - 1);
   localparam logic [SCLK_W-1:0] SCLK_RISE = SCLK_W'(SCLK_DIV - 1);

   localparam int              FRAME_BITS = 16;
   localparam logic [4:0]      BCNT_LAST  = 5'(FRAME_BITS);

`ifdef INERT_FAST_SIM_EN
   localparam logic [15:0] PWRUP_LAST = 16'd511;
`else
   localparam logic [15:0] PWRUP_LAST = 16'hFFFF;
`endif

   function automatic logic [15:0] state_cmd(input state_t s);
      logic [15:0] c;
      c = 16'h0000;
      unique case (s)
         INIT1:   c = INIT_CMD1;
         INIT2:   c = INIT_CMD2;
         INIT3:   c = INIT_CMD3;
         INIT4:   c = INIT_CMD4;
         RD1:     c = RD_CMD1;
         RD2:     c = RD_CMD2;
         RD3:     c = RD_CMD3;
         RD4:     c = RD_CMD4;
         RD5:     c = RD_CMD5;
         RD6:     c = RD_CMD6;
         RD7:     c = RD_CMD7;
         RD8:     c = RD_CMD8;
         default: c = 16'h0000;
      endcase
      return c;
   endfunction

   function automatic logic is_frame(input state_t s);
      return s inside {INIT1, INIT2, INIT3, INIT4,
                       RD1, RD2, RD3, RD4, RD5, RD6, RD7, RD8};
   endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit SPI monarch: MSB first, SCLK = clk/32 idling high, MOSI on fall,
// MISO sampled on rise, one-clk done as SS_n returns high.
module spi_mnrch
   import inert_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        snd,
   input  logic [15:0] cmd,
   output logic        done,
   output logic [15:0] resp,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   logic [SCLK_W-1:0] r_div;
   logic [4:0]        r_bcnt;
   logic [15:0]       r_shft;
   logic              r_miso;
   logic              r_ss_n;
   logic              r_done;

   logic              w_fall;
   logic              w_rise;
   logic              w_last;

   assign w_fall = !r_ss_n && (r_div == SCLK_FALL);
   assign w_rise = !r_ss_n && (r_div == SCLK_RISE);
   assign w_last = w_fall && (r_bcnt == BCNT_LAST);

   // The first fall only ends the front porch; later falls shift the
   // previously sampled bit in, and the would-be 17th fall ends the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ss_n <= 1'b1;
         r_div  <= '0;
         r_bcnt <= '0;
         r_shft <= '0;
         r_miso <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_ss_n) begin
            if (snd) begin
               r_ss_n <= 1'b0;
               r_div  <= '0;
               r_bcnt <= '0;
               r_shft <= cmd;
            end
         end else if (w_last) begin
            r_ss_n <= 1'b1;
            r_done <= 1'b1;
            r_div  <= '0;
            r_shft <= {r_shft[14:0], r_miso};
         end else begin
            r_div <= r_div + 1'b1;
            if (w_rise) begin
               r_miso <= MISO;
               r_bcnt <= r_bcnt + 5'd1;
            end
            if (w_fall && (r_bcnt != 5'd0)) begin
               r_shft <= {r_shft[14:0], r_miso};
            end
         end
      end
   end

   assign SS_n = r_ss_n;
   assign SCLK = r_ss_n | ~r_div[SCLK_W-1];
   assign MOSI = ~r_ss_n & r_shft[15];
   assign done = r_done;
   assign resp = r_shft;

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor interface: power-up wait, init writes, INT-driven reads.
// INERT_FAST_SIM_EN (see inert_pkg) shortens the power-up wait.
module inert_intf
   import inert_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               INT,
   input  logic               MISO,
   output logic               SS_n,
   output logic               SCLK,
   output logic               MOSI,
   output logic               vld,
   output logic signed [15:0] roll_rt,
   output logic signed [15:0] yaw_rt,
   output logic signed [15:0] AY,
   output logic signed [15:0] AZ
);

   state_t             r_state;
   state_t             w_nxt;

   logic [15:0]        r_tmr;
   logic               r_int_ff1;
   logic               r_int_ff2;

   logic               w_tmr_wrap;
   logic               w_snd;
   logic               w_done;
   logic               w_cap;
   logic [15:0]        w_cmd;
   logic [15:0]        w_resp;
   logic [7:0]         w_unused_resp_hi;

   logic [7:0]         r_roll_lo;
   logic [7:0]         r_roll_hi;
   logic [7:0]         r_yaw_lo;
   logic [7:0]         r_yaw_hi;
   logic [7:0]         r_ay_lo;
   logic [7:0]         r_ay_hi;
   logic [7:0]         r_az_lo;

   logic signed [15:0] r_roll;
   logic signed [15:0] r_yaw;
   logic signed [15:0] r_ay;
   logic signed [15:0] r_az;
   logic               r_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_int_ff1 <= 1'b0;
         r_int_ff2 <= 1'b0;
      end else begin
         r_int_ff1 <= INT;
         r_int_ff2 <= r_int_ff1;
      end
   end

   assign w_tmr_wrap = (r_state == PWRUP) && (r_tmr == PWRUP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmr <= '0;
      end else if (r_state == PWRUP) begin
         r_tmr <= w_tmr_wrap ? 16'h0000 : r_tmr + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PWRUP;
      end else begin
         r_state <= w_nxt;
      end
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         PWRUP:   if (w_tmr_wrap) w_nxt = INIT1;
         INIT1:   if (w_done) w_nxt = INIT2;
         INIT2:   if (w_done) w_nxt = INIT3;
         INIT3:   if (w_done) w_nxt = INIT4;
         INIT4:   if (w_done) w_nxt = IDLE;
         IDLE:    if (r_int_ff2) w_nxt = RD1;
         RD1:     if (w_done) w_nxt = RD2;
         RD2:     if (w_done) w_nxt = RD3;
         RD3:     if (w_done) w_nxt = RD4;
         RD4:     if (w_done) w_nxt = RD5;
         RD5:     if (w_done) w_nxt = RD6;
         RD6:     if (w_done) w_nxt = RD7;
         RD7:     if (w_done) w_nxt = RD8;
         RD8:     if (w_done) w_nxt = DONE;
         DONE:    w_nxt = IDLE;
         default: w_nxt = PWRUP;
      endcase
   end

   // A frame is launched only on entry to a frame state, so snd is a
   // single-clock pulse and never overlaps a frame in flight.
   always_comb begin
      w_snd = 1'b0;
      w_cmd = state_cmd(w_nxt);
      w_cap = (r_state == RD8) && w_done;
      if ((w_nxt != r_state) && is_frame(w_nxt)) begin
         w_snd = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_roll_lo <= 8'h00;
         r_roll_hi <= 8'h00;
         r_yaw_lo  <= 8'h00;
         r_yaw_hi  <= 8'h00;
         r_ay_lo   <= 8'h00;
         r_ay_hi   <= 8'h00;
         r_az_lo   <= 8'h00;
      end else if (w_done) begin
         unique case (r_state)
            RD1:     r_roll_lo <= w_resp[7:0];
            RD2:     r_roll_hi <= w_resp[7:0];
            RD3:     r_yaw_lo  <= w_resp[7:0];
            RD4:     r_yaw_hi  <= w_resp[7:0];
            RD5:     r_ay_lo   <= w_resp[7:0];
            RD6:     r_ay_hi   <= w_resp[7:0];
            RD7:     r_az_lo   <= w_resp[7:0];
            default: ;
         endcase
      end
   end

   // Visible outputs move only as a complete set, alongside vld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld  <= 1'b0;
         r_roll <= '0;
         r_yaw  <= '0;
         r_ay   <= '0;
         r_az   <= '0;
      end else begin
         r_vld <= w_cap;
         if (w_cap) begin
            r_roll <= {r_roll_hi, r_roll_lo};
            r_yaw  <= {r_yaw_hi, r_yaw_lo};
            r_ay   <= {r_ay_hi, r_ay_lo};
            r_az   <= {w_resp[7:0], r_az_lo};
         end
      end
   end

   spi_mnrch u_spi (
      .clk  (clk),
      .rst  (rst),
      .snd  (w_snd),
      .cmd  (w_cmd),
      .done (w_done),
      .resp (w_resp),
      .SS_n (SS_n),
      .SCLK (SCLK),
      .MOSI (MOSI),
      .MISO (MISO)
   );

   assign w_unused_resp_hi = w_resp[15:8];

   assign vld     = r_vld;
   assign roll_rt = r_roll;
   assign yaw_rt  = r_yaw;
   assign AY      = r_ay;
   assign AZ      = r_az;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: SPI sensor model plus command/output scoreboards.
`timescale 1ns/1ps
module tb_inert_intf;

`ifdef INERT_FAST_SIM_EN
   localparam int PWRUP_CLKS = 512;
   localparam int POST_RST_LIM = 512 + 100;
`else
   localparam int PWRUP_CLKS = 65536;
   localparam int POST_RST_LIM = 1500;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               INT;
   logic               MISO;
   logic               SS_n;
   logic               SCLK;
   logic               MOSI;
   logic               vld;
   logic signed [15:0] roll_rt;
   logic signed [15:0] yaw_rt;
   logic signed [15:0] AY;
   logic signed [15:0] AZ;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inert_intf dut (
      .clk     (clk),
      .rst     (rst),
      .INT     (INT),
      .MISO    (MISO),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI),
      .vld     (vld),
      .roll_rt (roll_rt),
      .yaw_rt  (yaw_rt),
      .AY      (AY),
      .AZ      (AZ)
   );

   logic [7:0]  regs [256];
   logic [15:0] q_exp_cmd [$];
   logic [15:0] q_obs_cmd [$];
   logic [63:0] q_exp_out [$];
   logic [63:0] q_obs_out [$];
   int          q_gap [$];

   int          cyc = 0;
   int          frame_bad = 0;
   int          vld_bad = 0;
   int          hold_bad = 0;
   int          vld_cnt = 0;
   int          cur_rises = 0;
   int          m_falls = 0;
   int          m_last_rise = 0;
   int          last_vld_cyc = 0;
   bit          armed = 0;
   logic        p_ss = 1'b1;
   logic        p_sclk = 1'b1;
   logic        p_vld = 1'b0;
   logic [15:0] m_rx = '0;
   logic [15:0] m_word = '0;
   logic [63:0] m_last_out = '0;
   logic [63:0] cur_out;

   // Sensor model and bus monitor, sampling 1ns after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      cur_out = {roll_rt, yaw_rt, AY, AZ};
      if (rst) begin
         p_ss = 1'b1;
         p_sclk = 1'b1;
         p_vld = 1'b0;
         cur_rises = 0;
         m_falls = 0;
         MISO = 1'b0;
         m_last_out = '0;
      end else begin
         if (p_ss && !SS_n) begin
            if (!SCLK) frame_bad++;
            if (armed) begin
               q_gap.push_back(cyc - last_vld_cyc);
               armed = 0;
            end
            cur_rises = 0;
            m_falls = 0;
            m_rx = '0;
            m_word = 16'hC300;
            MISO = m_word[15];
         end else if (!SS_n) begin
            if (!p_sclk && SCLK) begin
               if (cur_rises > 0 && (cyc - m_last_rise) != 32) frame_bad++;
               m_last_rise = cyc;
               cur_rises++;
               m_rx = {m_rx[14:0], MOSI};
            end
            if (p_sclk && !SCLK) begin
               m_falls++;
               if (m_falls == 9) m_word[7:0] = regs[m_rx[7:0]];
               if (m_falls > 1 && m_falls <= 16) MISO = m_word[16 - m_falls];
            end
         end else if (!p_ss && SS_n) begin
            if (!SCLK || cur_rises != 16) frame_bad++;
            q_obs_cmd.push_back(m_rx);
            MISO = 1'b0;
         end
         if (vld) begin
            if (p_vld) vld_bad++;
            vld_cnt++;
            q_obs_out.push_back(cur_out);
            last_vld_cyc = cyc;
            armed = 1;
            m_last_out = cur_out;
         end else if (cur_out !== m_last_out) begin
            hold_bad++;
         end
         p_vld = vld;
         p_ss = SS_n;
         p_sclk = SCLK;
      end
   end

   task automatic wait_cmds(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (q_obs_cmd.size() < n && c < budget) begin
         @(posedge clk);
         #2;
         c++;
      end
      ok = (q_obs_cmd.size() >= n);
   endtask

   task automatic wait_outs(input int n, input int budget, output bit ok);
      int c;
      c = 0;
      while (q_obs_out.size() < n && c < budget) begin
         @(posedge clk);
         #2;
         c++;
      end
      ok = (q_obs_out.size() >= n);
   endtask

   task automatic idle_clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      INT = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (SS_n !== 1'b1) begin
         errors++;
         $display("FAIL reset_ss_n got %b want 1", SS_n);
      end
      checks++;
      if (SCLK !== 1'b1) begin
         errors++;
         $display("FAIL reset_sclk got %b want 1", SCLK);
      end
      checks++;
      if (MOSI !== 1'b0) begin
         errors++;
         $display("FAIL reset_mosi got %b want 0", MOSI);
      end
      checks++;
      if (vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_vld got %b want 0", vld);
      end
      checks++;
      if ({roll_rt, yaw_rt, AY, AZ} !== 64'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0", {roll_rt, yaw_rt, AY, AZ});
      end
   endtask

   task automatic test_powerup();
      int n;
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (SS_n && n < PWRUP_CLKS + 64);
      checks++;
      if (n != PWRUP_CLKS) begin
         errors++;
         $display("FAIL powerup_wait got %0d want %0d", n, PWRUP_CLKS);
      end
   endtask

   task automatic test_init();
      bit ok;
      logic [15:0] e;
      logic [15:0] o;
      q_exp_cmd.push_back(16'h0D02);
      q_exp_cmd.push_back(16'h1053);
      q_exp_cmd.push_back(16'h1150);
      q_exp_cmd.push_back(16'h1460);
      wait_cmds(4, 3000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL init_timeout got %0d frames want 4", q_obs_cmd.size());
      end
      for (int i = 0; i < 4; i++) begin
         e = q_exp_cmd.pop_front();
         o = (q_obs_cmd.size() > 0) ? q_obs_cmd.pop_front() : 16'hxxxx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL init_cmd%0d got %h want %h", i, o, e);
         end
      end
      checks++;
      if (frame_bad != 0) begin
         errors++;
         $display("FAIL init_frame_shape got %0d bad want 0", frame_bad);
      end
   endtask

   task automatic push_reads(input int bursts);
      for (int b = 0; b < bursts; b++) begin
         q_exp_cmd.push_back(16'hA400);
         q_exp_cmd.push_back(16'hA500);
         q_exp_cmd.push_back(16'hA600);
         q_exp_cmd.push_back(16'hA700);
         q_exp_cmd.push_back(16'hAA00);
         q_exp_cmd.push_back(16'hAB00);
         q_exp_cmd.push_back(16'hAC00);
         q_exp_cmd.push_back(16'hAD00);
      end
   endtask

   task automatic test_single_read();
      bit ok;
      int v0;
      logic [15:0] e;
      logic [15:0] o;
      logic [63:0] eo;
      logic [63:0] oo;
      regs[8'hA4] = 8'h34;
      regs[8'hA5] = 8'h12;
      regs[8'hA6] = 8'h00;
      regs[8'hA7] = 8'h80;
      regs[8'hAA] = 8'h78;
      regs[8'hAB] = 8'h56;
      regs[8'hAC] = 8'hFF;
      regs[8'hAD] = 8'hFF;
      push_reads(1);
      q_exp_out.push_back({16'h1234, 16'h8000, 16'h5678, 16'hFFFF});
      idle_clks(20);
      v0 = vld_cnt;
      @(negedge clk);
      INT = 1'b1;
      repeat (3) @(negedge clk);
      INT = 1'b0;
      wait_outs(1, 5000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_vld_timeout got %0d want 1", q_obs_out.size());
      end
      idle_clks(100);
      checks++;
      if (q_obs_cmd.size() != 8) begin
         errors++;
         $display("FAIL single_frame_count got %0d want 8", q_obs_cmd.size());
      end
      for (int i = 0; i < 8; i++) begin
         e = q_exp_cmd.pop_front();
         o = (q_obs_cmd.size() > 0) ? q_obs_cmd.pop_front() : 16'hxxxx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL single_rd_cmd%0d got %h want %h", i, o, e);
         end
      end
      q_obs_cmd.delete();
      eo = q_exp_out.pop_front();
      oo = (q_obs_out.size() > 0) ? q_obs_out.pop_front() : 64'hx;
      checks++;
      if (oo[63:48] !== eo[63:48]) begin
         errors++;
         $display("FAIL single_roll got %h want %h", oo[63:48], eo[63:48]);
      end
      checks++;
      if (oo[47:32] !== eo[47:32]) begin
         errors++;
         $display("FAIL single_yaw got %h want %h", oo[47:32], eo[47:32]);
      end
      checks++;
      if (oo[31:16] !== eo[31:16]) begin
         errors++;
         $display("FAIL single_ay got %h want %h", oo[31:16], eo[31:16]);
      end
      checks++;
      if (oo[15:0] !== eo[15:0]) begin
         errors++;
         $display("FAIL single_az got %h want %h", oo[15:0], eo[15:0]);
      end
      checks++;
      if (vld_cnt - v0 != 1) begin
         errors++;
         $display("FAIL single_vld_count got %0d want 1", vld_cnt - v0);
      end
      checks++;
      if ({roll_rt, yaw_rt, AY, AZ} !== eo) begin
         errors++;
         $display("FAIL single_hold got %h want %h", {roll_rt, yaw_rt, AY, AZ}, eo);
      end
      checks++;
      if (hold_bad != 0 || vld_bad != 0 || frame_bad != 0) begin
         errors++;
         $display("FAIL single_integrity got %0d/%0d/%0d want 0/0/0",
                  hold_bad, vld_bad, frame_bad);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int v0;
      logic [15:0] e;
      logic [15:0] o;
      logic [63:0] eo;
      logic [63:0] oo;
      regs[8'hA4] = 8'hCD;
      regs[8'hA5] = 8'hAB;
      regs[8'hA6] = 8'h01;
      regs[8'hA7] = 8'h7F;
      regs[8'hAA] = 8'h00;
      regs[8'hAB] = 8'h00;
      regs[8'hAC] = 8'h01;
      regs[8'hAD] = 8'h00;
      push_reads(2);
      q_exp_out.push_back({16'hABCD, 16'h7F01, 16'h0000, 16'h0001});
      q_exp_out.push_back({16'hABCD, 16'h7F01, 16'h0000, 16'h0001});
      v0 = vld_cnt;
      @(negedge clk);
      INT = 1'b1;
      wait_cmds(1, 1000, ok);
      q_gap.delete();
      wait_cmds(10, 6000, ok);
      @(negedge clk);
      INT = 1'b0;
      wait_outs(2, 6000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_vld_timeout got %0d want 2", q_obs_out.size());
      end
      idle_clks(100);
      checks++;
      if (q_obs_cmd.size() != 16) begin
         errors++;
         $display("FAIL b2b_frame_count got %0d want 16", q_obs_cmd.size());
      end
      for (int i = 0; i < 16; i++) begin
         e = q_exp_cmd.pop_front();
         o = (q_obs_cmd.size() > 0) ? q_obs_cmd.pop_front() : 16'hxxxx;
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_rd_cmd%0d got %h want %h", i, o, e);
         end
      end
      q_obs_cmd.delete();
      for (int i = 0; i < 2; i++) begin
         eo = q_exp_out.pop_front();
         oo = (q_obs_out.size() > 0) ? q_obs_out.pop_front() : 64'hx;
         checks++;
         if (oo !== eo) begin
            errors++;
            $display("FAIL b2b_out%0d got %h want %h", i, oo, eo);
         end
      end
      checks++;
      if (vld_cnt - v0 != 2) begin
         errors++;
         $display("FAIL b2b_vld_count got %0d want 2", vld_cnt - v0);
      end
      checks++;
      if (q_gap.size() < 1 || q_gap[0] != 2) begin
         errors++;
         $display("FAIL b2b_restart_gap got %0d want 2",
                  (q_gap.size() > 0) ? q_gap[0] : -1);
      end
      checks++;
      if (hold_bad != 0 || vld_bad != 0 || frame_bad != 0) begin
         errors++;
         $display("FAIL b2b_integrity got %0d/%0d/%0d want 0/0/0",
                  hold_bad, vld_bad, frame_bad);
      end
   endtask

   task automatic test_rst_midframe();
      bit ok;
      int c;
      int n;
      logic [15:0] o;
      q_exp_cmd.push_back(16'hA400);
      q_exp_cmd.push_back(16'hA500);
      @(negedge clk);
      INT = 1'b1;
      repeat (3) @(negedge clk);
      INT = 1'b0;
      wait_cmds(2, 2000, ok);
      c = 0;
      while (!(!SS_n && cur_rises == 7) && c < 1000) begin
         @(posedge clk);
         #2;
         c++;
      end
      checks++;
      if (c >= 1000) begin
         errors++;
         $display("FAIL rst_rd3_timeout got %0d want <1000", c);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (SS_n !== 1'b1 || SCLK !== 1'b1 || MOSI !== 1'b0 || vld !== 1'b0) begin
         errors++;
         $display("FAIL rst_bus got %b%b%b%b want 1100", SS_n, SCLK, MOSI, vld);
      end
      checks++;
      if ({roll_rt, yaw_rt, AY, AZ} !== 64'h0) begin
         errors++;
         $display("FAIL rst_outputs got %h want 0", {roll_rt, yaw_rt, AY, AZ});
      end
      for (int i = 0; i < 2; i++) begin
         o = (q_obs_cmd.size() > 0) ? q_obs_cmd.pop_front() : 16'hxxxx;
         checks++;
         if (o !== q_exp_cmd[0]) begin
            errors++;
            $display("FAIL rst_pre_cmd%0d got %h want %h", i, o, q_exp_cmd[0]);
         end
         void'(q_exp_cmd.pop_front());
      end
      repeat (3) @(posedge clk);
      checks++;
      if (q_obs_cmd.size() != 0) begin
         errors++;
         $display("FAIL rst_partial_frame got %0d want 0", q_obs_cmd.size());
      end
      q_obs_cmd.delete();
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (SS_n && n < POST_RST_LIM);
`ifdef INERT_FAST_SIM_EN
      checks++;
      if (n != PWRUP_CLKS) begin
         errors++;
         $display("FAIL rst_rewait got %0d want %0d", n, PWRUP_CLKS);
      end
      wait_cmds(1, 1000, ok);
      o = (q_obs_cmd.size() > 0) ? q_obs_cmd.pop_front() : 16'hxxxx;
      checks++;
      if (o !== 16'h0D02) begin
         errors++;
         $display("FAIL rst_init_restart got %h want 0d02", o);
      end
`else
      checks++;
      if (SS_n !== 1'b1 || n != POST_RST_LIM) begin
         errors++;
         $display("FAIL rst_rewait got %0d clks high want %0d", n, POST_RST_LIM);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      INT = 1'b0;
      for (int i = 0; i < 256; i++) regs[i] = 8'h00;
      test_reset();
      test_powerup();
      test_init();
      test_single_read();
      test_back_to_back();
      test_rst_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
